// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB completer backed by a byte-wide register memory with programmable wait states
module apb_slave_mem #(
    parameter int unsigned DEPTH       = 12,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [3:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);
    localparam logic [4:0] DEPTH_L   = 5'(DEPTH);
    localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

    state_e     state_q, state_d;
    logic [3:0] addr_q, addr_d;
    logic       wr_q, wr_d;
    logic [2:0] cnt_q, cnt_d;
    logic       pready_q, pready_d;
    logic       pslverr_q, pslverr_d;
    logic [7:0] prdata_q, prdata_d;

    logic [7:0] mem_q [DEPTH];
    logic       mem_we;

    // Address/direction the response is built from: live bus on the setup edge, latched copy afterwards.
    logic [3:0] resp_addr;
    logic       resp_wr;
    logic       resp_in_range;
    logic [7:0] rd_byte;

    // Select the response source and fetch the addressed byte (0x00 when out of range).
    always_comb begin
        resp_addr     = (state_q == IDLE) ? paddr : addr_q;
        resp_wr       = (state_q == IDLE) ? pwrite : wr_q;
        resp_in_range = ({1'b0, resp_addr} < DEPTH_L);
        rd_byte       = 8'h00;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (resp_addr == 4'(i)) begin
                rd_byte = mem_q[i];
            end
        end
    end

    // Next-state and registered-response logic for the two-state transfer FSM.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        cnt_d     = cnt_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        mem_we    = 1'b0;

        case (state_q)
            IDLE: begin
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = 8'h00;
                if (psel && !penable) begin
                    state_d = ACCESS;
                    addr_d  = paddr;
                    wr_d    = pwrite;
                    cnt_d   = WAIT_INIT;
                    if (NO_WAIT) begin
                        pready_d  = 1'b1;
                        pslverr_d = !resp_in_range;
                        prdata_d  = (!resp_wr && resp_in_range) ? rd_byte : 8'h00;
                    end
                end
            end

            ACCESS: begin
                if (!psel) begin
                    // Abort: requester walked away, nothing is written.
                    state_d   = IDLE;
                    cnt_d     = 3'd0;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = 8'h00;
                end else if (penable && pready_q) begin
                    // Completion edge: commit an in-range write, drop the response.
                    state_d   = IDLE;
                    cnt_d     = 3'd0;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = 8'h00;
                    mem_we    = wr_q && ({1'b0, addr_q} < DEPTH_L);
                end else if (penable && (cnt_q != 3'd0)) begin
                    // Count down wait states; saturates at zero so it cannot wrap.
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        pready_d  = 1'b1;
                        pslverr_d = !resp_in_range;
                        prdata_d  = (!resp_wr && resp_in_range) ? rd_byte : 8'h00;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM, latched request and response registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= IDLE;
            addr_q    <= 4'h0;
            wr_q      <= 1'b0;
            cnt_q     <= 3'd0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= 8'h00;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    // Register memory, cleared by reset, written on the completion edge with the live pwdata.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (mem_we && (addr_q == 4'(i))) begin
                    mem_q[i] <= pwdata;
                end
            end
        end
    end

    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign prdata  = prdata_q;

endmodule
